// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for
// the 6-bit CPU. Fetches instructions over a req/ack handshake, holds them in
// the IR, keeps the CPU flag register and updates the PC from the control
// unit's branch decision.
module cpu_sequencer #(
    parameter int         AW      = 6,
    parameter int         IW      = 10,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [3:0]    opcode,
    output logic [AW-1:0] operand,
    input  logic          cu_jmp_sel,
    input  logic          cu_reg_en,
    input  logic          alu_cf,
    input  logic          alu_sf,
    input  logic          alu_zf,
    output logic          flag_cf,
    output logic          flag_sf,
    output logic          flag_zf,
    output logic          reg_we,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_ir;
    logic          r_cf;
    logic          r_sf;
    logic          r_zf;

    logic [3:0]    w_opcode;
    logic [AW-1:0] w_operand;
    logic [AW-1:0] w_pcNext;

    // Opcode/target fields come straight from the IR so they only move when
    // a fetch is acknowledged; the sequential PC wraps naturally at 2^AW.
    assign w_opcode  = r_ir[IW-1:IW-4];
    assign w_operand = r_ir[AW-1:0];
    assign w_pcNext  = r_pc + {{(AW-1){1'b0}}, 1'b1};

    assign opcode    = w_opcode;
    assign operand   = w_operand;
    assign imem_addr = r_pc;
    assign flag_cf   = r_cf;
    assign flag_sf   = r_sf;
    assign flag_zf   = r_zf;

    // Handshake/status outputs are decoded from the state register alone, so
    // an asynchronous reset drops imem_req immediately.
    assign imem_req  = (r_state == S_FETCH);
    assign halted    = (r_state == S_HALT);
    assign reg_we    = (r_state == S_WB) && cu_reg_en;

    // Main sequencer: one instruction per FETCH->DECODE->EXEC->WB pass, with
    // the PC only advanced in WB so a stopped sequencer resumes where it left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cf    <= 1'b0;
            r_sf    <= 1'b0;
            r_zf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_opcode == HALT_OP) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_opcode[3]) begin
                        r_cf <= alu_cf;
                        r_sf <= alu_sf;
                        r_zf <= alu_zf;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_pc    <= cu_jmp_sel ? w_operand : w_pcNext;
                    r_state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer. A directed vector
// table walks the ALU/branch/wait-state/run-drop/wrap cases, then randomized
// instructions are checked against an instruction-level reference model,
// followed by hand-written HALT and mid-fetch reset sequences.
module tb_cpu_sequencer;

    logic       clk;
    logic       rstN;
    logic       run;
    logic       imemReq;
    logic [5:0] imemAddr;
    logic       imemAck;
    logic [9:0] imemData;
    logic [3:0] opcode;
    logic [5:0] operand;
    logic       cuJmpSel;
    logic       cuRegEn;
    logic       aluCf;
    logic       aluSf;
    logic       aluZf;
    logic       flagCf;
    logic       flagSf;
    logic       flagZf;
    logic       regWe;
    logic       halted;

    int checkCount;
    int passCount;

    logic [5:0] curPc;
    logic [9:0] curIr;
    logic [2:0] curFlags;

    typedef struct {
        logic [9:0] instr;
        int         delay;
        logic [2:0] alu;
        logic       runAfter;
        logic [5:0] expPc;
        logic       expWe;
        logic [2:0] expFlags;
    } vec_t;

    vec_t vecs[12];

    cpu_sequencer #(
        .AW(6),
        .IW(10),
        .HALT_OP(4'hF)
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .run(run),
        .imem_req(imemReq),
        .imem_addr(imemAddr),
        .imem_ack(imemAck),
        .imem_data(imemData),
        .opcode(opcode),
        .operand(operand),
        .cu_jmp_sel(cuJmpSel),
        .cu_reg_en(cuRegEn),
        .alu_cf(aluCf),
        .alu_sf(aluSf),
        .alu_zf(aluZf),
        .flag_cf(flagCf),
        .flag_sf(flagSf),
        .flag_zf(flagZf),
        .reg_we(regWe),
        .halted(halted)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaves like the control unit: which ops write a register.
    function automatic logic cuRegEnF(input logic [3:0] op);
        return (op[3] == 1'b0) && (op != 4'h7);
    endfunction

    // Behaves like the control unit: branch decision from {cf,sf,zf}.
    function automatic logic cuJmpF(input logic [3:0] op, input logic [2:0] f);
        case (op)
            4'h8:    return 1'b1;
            4'h9:    return !f[1] || f[0];
            4'hA:    return f[0];
            4'hB:    return f[2];
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: result of executing one instruction.
    task automatic refStep(input logic [9:0] instr, input logic [2:0] alu,
                           input logic [5:0] pc, input logic [2:0] flagsIn,
                           output logic [5:0] pcOut, output logic weOut,
                           output logic [2:0] flagsOut);
        logic [3:0] op;
        logic       jmp;
        op       = instr[9:6];
        flagsOut = op[3] ? flagsIn : alu;
        jmp      = op[3] ? cuJmpF(op, flagsOut) : 1'b0;
        pcOut    = jmp ? instr[5:0] : 6'((int'(pc) + 1) % 64);
        weOut    = cuRegEnF(op);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Randomize every input the DUT should ignore in the current cycle.
    task automatic driveNoise();
        imemAck  = 1'($urandom);
        imemData = 10'($urandom);
        aluCf    = 1'($urandom);
        aluSf    = 1'($urandom);
        aluZf    = 1'($urandom);
        cuJmpSel = 1'($urandom);
        cuRegEn  = 1'($urandom);
    endtask

    // Runs one instruction from FETCH through WB (plus an IDLE gap when run
    // drops) and checks the visible behaviour of every cycle.
    task automatic applyStimulus(input string tag, input logic [9:0] instr,
                                 input int delay, input logic [2:0] alu,
                                 input logic runAfter, input logic [5:0] expPc,
                                 input logic expWe, input logic [2:0] expFlags);
        logic [3:0] op;
        op = instr[9:6];
        for (int w = 0; w <= delay; w++) begin
            @(negedge clk);
            driveNoise();
            run      = 1'($urandom);
            imemAck  = (w == delay);
            imemData = (w == delay) ? instr : 10'($urandom);
            #1;
            checkOutput({tag, " fetch req"}, 16'(imemReq), 16'(1));
            checkOutput({tag, " fetch addr"}, 16'(imemAddr), 16'(curPc));
            checkOutput({tag, " fetch ir hold"}, 16'({opcode, operand}), 16'(curIr));
            checkOutput({tag, " fetch we"}, 16'(regWe), 16'(0));
        end
        @(negedge clk);
        driveNoise();
        run = 1'($urandom);
        #1;
        checkOutput({tag, " decode req"}, 16'(imemReq), 16'(0));
        checkOutput({tag, " decode ir"}, 16'({opcode, operand}), 16'(instr));
        checkOutput({tag, " decode we"}, 16'(regWe), 16'(0));
        curIr = instr;
        @(negedge clk);
        driveNoise();
        {aluCf, aluSf, aluZf} = alu;
        run = runAfter;
        #1;
        checkOutput({tag, " exec req"}, 16'(imemReq), 16'(0));
        checkOutput({tag, " exec we"}, 16'(regWe), 16'(0));
        checkOutput({tag, " exec flags"}, 16'({flagCf, flagSf, flagZf}), 16'(curFlags));
        @(negedge clk);
        driveNoise();
        cuRegEn  = cuRegEnF(op);
        cuJmpSel = cuJmpF(op, expFlags);
        #1;
        checkOutput({tag, " wb we"}, 16'(regWe), 16'(expWe));
        checkOutput({tag, " wb flags"}, 16'({flagCf, flagSf, flagZf}), 16'(expFlags));
        checkOutput({tag, " wb req"}, 16'(imemReq), 16'(0));
        checkOutput({tag, " wb ir"}, 16'({opcode, operand}), 16'(instr));
        curPc    = expPc;
        curFlags = expFlags;
        if (!runAfter) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                driveNoise();
                run = (i == 2);
                #1;
                checkOutput({tag, " idle req"}, 16'(imemReq), 16'(0));
                checkOutput({tag, " idle addr"}, 16'(imemAddr), 16'(curPc));
                checkOutput({tag, " idle we"}, 16'(regWe), 16'(0));
            end
        end
    endtask

    // Fetches HALT_OP and confirms the sequencer stays parked whatever run does.
    task automatic haltSequence(input logic [9:0] instr);
        @(negedge clk);
        driveNoise();
        imemAck  = 1'b1;
        imemData = instr;
        #1;
        checkOutput("halt fetch req", 16'(imemReq), 16'(1));
        checkOutput("halt fetch addr", 16'(imemAddr), 16'(curPc));
        @(negedge clk);
        driveNoise();
        #1;
        checkOutput("halt decode op", 16'(opcode), 16'(4'hF));
        checkOutput("halt decode halted", 16'(halted), 16'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            driveNoise();
            run     = i[0];
            cuRegEn = 1'b1;
            #1;
            checkOutput("halted flag", 16'(halted), 16'(1));
            checkOutput("halted req", 16'(imemReq), 16'(0));
            checkOutput("halted we", 16'(regWe), 16'(0));
            checkOutput("halted pc", 16'(imemAddr), 16'(curPc));
        end
    endtask

    // Test sequence: reset, directed table, random program, HALT, reset.
    initial begin
        logic [9:0] rInstr;
        logic [2:0] rAlu;
        logic [5:0] rPc;
        logic       rWe;
        logic [2:0] rFlags;
        logic       rRun;

        checkCount = 0;
        passCount  = 0;

        vecs[0]  = '{10'h000, 0, 3'b000, 1'b1, 6'd1,  1'b1, 3'b000};
        vecs[1]  = '{10'h005, 0, 3'b010, 1'b1, 6'd2,  1'b1, 3'b010};
        vecs[2]  = '{10'h00A, 0, 3'b010, 1'b1, 6'd3,  1'b1, 3'b010};
        vecs[3]  = '{10'h214, 0, 3'b111, 1'b1, 6'd20, 1'b0, 3'b010};
        vecs[4]  = '{10'h268, 0, 3'b101, 1'b1, 6'd21, 1'b0, 3'b010};
        vecs[5]  = '{10'h043, 3, 3'b001, 1'b1, 6'd22, 1'b1, 3'b001};
        vecs[6]  = '{10'h268, 0, 3'b110, 1'b1, 6'd40, 1'b0, 3'b001};
        vecs[7]  = '{10'h089, 1, 3'b100, 1'b0, 6'd41, 1'b1, 3'b100};
        vecs[8]  = '{10'h0C0, 0, 3'b000, 1'b1, 6'd42, 1'b1, 3'b000};
        vecs[9]  = '{10'h1FF, 2, 3'b110, 1'b1, 6'd43, 1'b0, 3'b110};
        vecs[10] = '{10'h23F, 0, 3'b011, 1'b1, 6'd63, 1'b0, 3'b110};
        vecs[11] = '{10'h001, 0, 3'b000, 1'b1, 6'd0,  1'b1, 3'b000};

        rstN = 1'b0;
        run  = 1'b0;
        driveNoise();
        curPc    = '0;
        curIr    = '0;
        curFlags = '0;
        #2;
        checkOutput("reset req", 16'(imemReq), 16'(0));
        checkOutput("reset addr", 16'(imemAddr), 16'(0));
        checkOutput("reset ir", 16'({opcode, operand}), 16'(0));
        checkOutput("reset flags", 16'({flagCf, flagSf, flagZf}), 16'(0));
        checkOutput("reset we", 16'(regWe), 16'(0));
        checkOutput("reset halted", 16'(halted), 16'(0));

        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        run  = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].instr, vecs[i].delay,
                          vecs[i].alu, vecs[i].runAfter, vecs[i].expPc,
                          vecs[i].expWe, vecs[i].expFlags);
        end

        for (int n = 0; n < 40; n++) begin
            rInstr = {4'($urandom_range(0, 14)), 6'($urandom)};
            rAlu   = 3'($urandom);
            rRun   = ($urandom_range(0, 4) != 0);
            refStep(rInstr, rAlu, curPc, curFlags, rPc, rWe, rFlags);
            applyStimulus($sformatf("rnd%0d", n), rInstr, $urandom_range(0, 2),
                          rAlu, rRun, rPc, rWe, rFlags);
        end

        rInstr = {4'h8, 6'd5};
        refStep(rInstr, 3'b000, curPc, curFlags, rPc, rWe, rFlags);
        applyStimulus("jmp5", rInstr, 0, 3'b000, 1'b1, rPc, rWe, rFlags);
        haltSequence({4'hF, 6'h2A});

        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("halt reset halted", 16'(halted), 16'(0));
        checkOutput("halt reset pc", 16'(imemAddr), 16'(0));
        @(negedge clk);
        rstN     = 1'b1;
        run      = 1'b1;
        curPc    = '0;
        curIr    = '0;
        curFlags = '0;
        applyStimulus("jmp17", {4'h8, 6'd17}, 0, 3'b000, 1'b1, 6'd17, 1'b0, 3'b000);

        @(negedge clk);
        driveNoise();
        imemAck = 1'b0;
        #1;
        checkOutput("midfetch req", 16'(imemReq), 16'(1));
        checkOutput("midfetch addr", 16'(imemAddr), 16'(17));
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset req", 16'(imemReq), 16'(0));
        checkOutput("async reset pc", 16'(imemAddr), 16'(0));
        checkOutput("async reset ir", 16'({opcode, operand}), 16'(0));
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
